serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_if.sv | 24 ++
 rtl/serial_adder.sv | 81 ++++++++
 tb/tb_serial_adder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: requester drives start and
// operands, the adder returns busy/done status and the registered result.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;

    modport master (
        output start, A, B, Cin,
        input  busy, done, Sum, Cout
    );

    modport slave (
        input  start, A, B, Cin,
        output busy, done, Sum, Cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell walks the operands LSB first over
// WIDTH cycles, then publishes {Cout,Sum} for a single DONE cycle.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_adder_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             s_bit;
    logic             c_bit;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
        c_bit    = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        res_next = {s_bit, res_sh[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh   <= bus.A;
                        b_sh   <= bus.B;
                        carry  <= bus.Cin;
                        res_sh <= '0;
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    res_sh <= res_next;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= c_bit;
                    // Counter wraps to 0 on the final bit so it never reaches WIDTH.
                    if (cnt == LAST) begin
                        cnt    <= '0;
                        sum_q  <= res_next;
                        cout_q <= c_bit;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
    assign bus.Sum  = sum_q;
    assign bus.Cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): stimulus pushes hand-computed
// {Cout,Sum} into a scoreboard that a done-triggered monitor drains.
module tb_serial_adder;
    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    int pushes = 0;
    logic [8:0] sb[$];

    serial_adder_if #(.WIDTH(8)) bus();

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            logic [8:0] exp;
            done_count++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                exp = sb.pop_front();
                check("sum", 32'(bus.Sum), 32'(exp[7:0]));
                check("cout", 32'(bus.Cout), 32'(exp[8]));
                check("busy_at_done", 32'(bus.busy), 32'd0);
            end
        end
    end

    // Issue one addition; optionally poke start during SHIFT (intrude) and during DONE.
    task automatic run_add(input logic [7:0] a, input logic [7:0] b, input logic cin,
                           input logic [8:0] exp, input int intrude);
        int nbusy;
        int cyc;
        int dc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = a;
        bus.B = b;
        bus.Cin = cin;
        sb.push_back(exp);
        pushes++;
        dc = done_count;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A = ~a;
        bus.B = ~b;
        bus.Cin = ~cin;
        nbusy = 0;
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 20) begin
            nbusy++;
            if (intrude > 0 && nbusy == intrude) begin
                bus.start = 1'b1;
                bus.A = 8'h80;
                bus.B = 8'h80;
                bus.Cin = 1'b0;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check("busy_len", 32'(nbusy), 32'd8);
        check("done_after_busy", 32'(bus.done), 32'd1);
        if (intrude > 0) begin
            bus.start = 1'b1;
            bus.A = 8'h33;
            bus.B = 8'h44;
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("done_single", 32'(bus.done), 32'd0);
        check("idle_not_busy", 32'(bus.busy), 32'd0);
        check("one_done_pulse", 32'(done_count - dc), 32'd1);
        repeat (3) @(negedge clk);
        check("sum_hold", 32'(bus.Sum), 32'(exp[7:0]));
        check("cout_hold", 32'(bus.Cout), 32'(exp[8]));
    endtask

    initial begin
        int nbusy;
        int dc;
        rst_n = 1'b0;
        bus.start = 1'b1;
        bus.A = 8'hFF;
        bus.B = 8'hFF;
        bus.Cin = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        check("rst_busy_after", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.Sum), 32'd0);
        check("rst_cout", 32'(bus.Cout), 32'd0);

        run_add(8'h0F, 8'h01, 1'b0, 9'h010, 0);
        run_add(8'hFF, 8'h01, 1'b0, 9'h100, 0);
        run_add(8'hFF, 8'hFF, 1'b1, 9'h1FF, 0);
        run_add(8'h3C, 8'hC3, 1'b0, 9'h0FF, 0);
        run_add(8'h05, 8'h03, 1'b0, 9'h008, 3);

        // Reset asserted so that the 4th SHIFT edge samples it.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = 8'hAA;
        bus.B = 8'h55;
        bus.Cin = 1'b0;
        dc = done_count;
        @(negedge clk);
        bus.start = 1'b0;
        nbusy = 1;
        while (nbusy < 4 && bus.busy === 1'b1) begin
            @(negedge clk);
            nbusy++;
        end
        check("mid_busy_reached", 32'(nbusy), 32'd4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_sum", 32'(bus.Sum), 32'd0);
        check("mid_rst_cout", 32'(bus.Cout), 32'd0);
        repeat (12) @(negedge clk);
        check("mid_rst_no_done", 32'(done_count - dc), 32'd0);

        run_add(8'h01, 8'h02, 1'b1, 9'h004, 0);

        repeat (4) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("total_done", 32'(done_count), 32'(pushes));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
